mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single byte-wide unified RAM port between the instruction-fetch stage and the MEM-stage data access. Serialises each request into 1–4 byte transfers, assembles little-endian read data, and raises a stall request to the pipeline controller while any access is outstanding. Sits between the IF/MEM stages and the external RAM model.

## Interface
- No parameters; data width is 32 bits and RAM width is 8 bits, both fixed.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held high until if_done is seen.
- if_addr  in  32  fetch address; always a word (4-byte) read.
- if_data  out  32  fetched instruction; valid while if_done is high.
- if_done  out  1  one-cycle completion pulse for a fetch.
- mem_req  in  1  data request; held high until mem_done is seen.
- mem_we  in  1  1 = write, 0 = read.
- mem_width  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- mem_addr  in  32  data base address.
- mem_wdata  in  32  write data; byte i is bits [8i+7:8i].
- mem_rdata  out  32  read data, zero-filled above the access width; valid while mem_done is high.
- mem_done  out  1  one-cycle completion pulse for a data access.
- ram_addr  out  32  RAM byte address.
- ram_wr  out  1  RAM write strobe for the current byte.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte; returns the byte for the address driven in the previous cycle.
- stall_req  out  1  combinational: (if_req & ~if_done) | (mem_req & ~mem_done); forced to 0 while rst is high.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any request is present, grant one, latch its address, width, we and wdata, set n (1/2/4), set cnt=0, and go to BUSY.
  - If no request is present, stay in IDLE.
- Grant rule: MEM has priority over IF (MEM holds the older instruction).
- BUSY, issue phase (cnt < n):
  - Drive ram_addr = base + cnt, with 32-bit wrap-around (0xFFFFFFFF + 1 = 0x00000000).
  - Write: ram_wr=1 and ram_dout = byte cnt of the latched wdata.
  - Read: ram_wr=0; the byte returned in the next cycle is captured into lane cnt of the assembly register.
  - cnt increments every cycle.
- BUSY, end: after the final issue cycle, one extra cycle captures the last read byte. Writes skip this capture cycle. Then go to DONE.
- DONE:
  - Pulse the granted requester's done signal for exactly one cycle, with its data stable.
  - Arbitration is ignored in this cycle.
  - Next state is IDLE.
- Outside issue cycles: ram_wr=0, and ram_addr holds its last value.
- Assembly register is cleared on each new grant, so unused upper lanes read 0.
- Requests are not preempted. A request arriving during BUSY waits until the next IDLE cycle.
- Reset values (all registered outputs): ram_addr=0, ram_wr=0, ram_dout=0, if_data=0, if_done=0, mem_rdata=0, mem_done=0; state=IDLE; cnt=0.
- Reset mid-operation: abort immediately to IDLE. No further ram_wr pulses. Bytes already written stay in RAM. No done pulse is issued.

## Timing
Cycle 0 is the IDLE cycle in which the request is sampled.
- Word read: addresses driven in cycles 1–4; bytes captured in cycles 2–5; done high in cycle 6; IDLE in cycle 7.
- Half read: done in cycle 4. Byte read: done in cycle 3.
- Word write: ram_wr high in cycles 1–4; done in cycle 5. Half write: done in cycle 3. Byte write: done in cycle 2.
- Back-to-back: a request held through DONE (new request, or the loser of a tie) is granted at the following IDLE cycle. Minimum gap between accesses is one IDLE cycle.
- Requester contract: drop or change req in the cycle after done. The arbiter never re-grants inside DONE.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - A last_grant register (reset value = IF) resolves simultaneous requests in IDLE in favour of the requester not granted last.
  - The first tie after reset therefore goes to MEM.
  - A single requester is always granted.
- ARB_ROUND_ROBIN_EN undefined: fixed MEM-over-IF priority; no last_grant register.

## Test plan
- Word fetch: if_req, if_addr=0x100, RAM[0x100..0x103]=13 05 A0 00 -> ram_addr 0x100..0x103 in cycles 1–4; if_done in cycle 6 with if_data=0x00A00513; stall_req high in cycles 0–5.
- Byte write plus half read: mem_we=1, width=00, addr=0x2003, wdata=0xDEADBEEF -> single ram_wr in cycle 1 with ram_dout=0xEF at 0x2003; mem_done in cycle 2. Then a half read at 0x2002 (RAM 0x11, 0xEF) -> mem_rdata=0x0000EF11.
- Simultaneous requests in cycle 0, macro off -> MEM served first (done cycle 6 for a word read); IF granted at the next IDLE; if_done 7 cycles after mem_done.
- Same tie with ARB_ROUND_ROBIN_EN, repeated twice -> grants MEM, IF, MEM, IF.
- Wrap-around: word read at 0xFFFFFFFE -> ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset in cycle 2 of a word write -> ram_wr seen only in cycle 1; all outputs at reset values next cycle; no mem_done; a request re-presented after reset completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle of mem_arbiter: IF and MEM stage handshakes, byte RAM port, stall.
// The arbiter connects through the slave modport; the requesters and RAM side use master.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_data;
   logic        if_done;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_width;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic        stall_req;

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata, ram_din,
      input  if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, stall_req
   );

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata, ram_din,
      output if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, stall_req
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and MEM-stage data accesses.
// Define ARB_ROUND_ROBIN_EN to resolve simultaneous requests round-robin instead of MEM-first.
module mem_arbiter (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  n_q, n_d;
   logic        gnt_mem_q, gnt_mem_d;
   logic        we_q, we_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] ram_addr_q, ram_addr_d;
   logic        ram_wr_q, ram_wr_d;
   logic [7:0]  ram_dout_q, ram_dout_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        if_done_q, if_done_d;
   logic        mem_done_q, mem_done_d;

   logic        pick_mem;
   logic [2:0]  cnt_nxt;
   logic [1:0]  lane;
   logic [31:0] asm_cap;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_mem_q, last_mem_d;

   assign pick_mem   = bus.mem_req & (~bus.if_req | ~last_mem_q);
   assign last_mem_d = (state_q == IDLE && (bus.if_req || bus.mem_req)) ? pick_mem : last_mem_q;
`else
   assign pick_mem = bus.mem_req;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      gnt_mem_d   = gnt_mem_q;
      we_d        = we_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      asm_d       = asm_q;
      ram_addr_d  = ram_addr_q;
      ram_wr_d    = 1'b0;
      ram_dout_d  = ram_dout_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;

      // cnt_q is the byte currently on the RAM port; ram_din holds byte cnt_q-1
      cnt_nxt = cnt_q + 3'd1;
      lane    = cnt_q[1:0] - 2'd1;
      asm_cap = asm_q;
      asm_cap[{lane, 3'b000} +: 8] = bus.ram_din;

      unique case (state_q)
         IDLE: begin
            if (bus.if_req || bus.mem_req) begin
               gnt_mem_d = pick_mem;
               if (pick_mem) begin
                  base_d  = bus.mem_addr;
                  we_d    = bus.mem_we;
                  wdata_d = bus.mem_wdata;
                  unique case (bus.mem_width)
                     2'b00:   n_d = 3'd1;
                     2'b01:   n_d = 3'd2;
                     default: n_d = 3'd4;
                  endcase
               end else begin
                  base_d  = bus.if_addr;
                  we_d    = 1'b0;
                  wdata_d = 32'd0;
                  n_d     = 3'd4;
               end
               cnt_d      = 3'd0;
               asm_d      = 32'd0;
               ram_addr_d = base_d;
               ram_wr_d   = we_d;
               if (we_d) ram_dout_d = wdata_d[7:0];
               state_d    = BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_nxt;
            if (!we_q && cnt_q != 3'd0) asm_d = asm_cap;
            if (cnt_nxt < n_q) begin
               ram_addr_d = base_q + {29'd0, cnt_nxt};
               ram_wr_d   = we_q;
               if (we_q) ram_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
            end
            // writes finish after the last issue; reads need one more cycle to catch the last byte
            if ((we_q && cnt_nxt == n_q) || (!we_q && cnt_q == n_q)) begin
               state_d = DONE;
               cnt_d   = 3'd0;
               if (gnt_mem_q) begin
                  mem_done_d = 1'b1;
                  if (!we_q) mem_rdata_d = asm_cap;
               end else begin
                  if_done_d = 1'b1;
                  if_data_d = asm_cap;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         n_q         <= 3'd0;
         gnt_mem_q   <= 1'b0;
         we_q        <= 1'b0;
         base_q      <= 32'd0;
         wdata_q     <= 32'd0;
         asm_q       <= 32'd0;
         ram_addr_q  <= 32'd0;
         ram_wr_q    <= 1'b0;
         ram_dout_q  <= 8'd0;
         if_data_q   <= 32'd0;
         mem_rdata_q <= 32'd0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_mem_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         gnt_mem_q   <= gnt_mem_d;
         we_q        <= we_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         asm_q       <= asm_d;
         ram_addr_q  <= ram_addr_d;
         ram_wr_q    <= ram_wr_d;
         ram_dout_q  <= ram_dout_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_mem_q  <= last_mem_d;
`endif
      end
   end

   // Reset must stop a write strobe already registered for the current cycle
   assign bus.ram_wr    = ram_wr_q & ~rst;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_dout  = ram_dout_q;
   assign bus.if_data   = if_data_q;
   assign bus.if_done   = if_done_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.mem_done  = mem_done_q;
   assign bus.stall_req = ~rst & ((bus.if_req & ~if_done_q) | (bus.mem_req & ~mem_done_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte RAM model plus a transaction-level reference memory.
// Directed cases (fetch, byte write/half read, ties, wrap, reset abort) then randomized accesses.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0] ramMem [logic [31:0]];
   logic [7:0] refMem [logic [31:0]];
   bit lastGrantMem = 1'b0;

   // Byte RAM: read data appears one cycle after its address
   always @(posedge clk) begin
      logic [7:0] rd;
      rd = ramMem.exists(bus.ram_addr) ? ramMem[bus.ram_addr] : 8'h00;
      if (bus.ram_wr) ramMem[bus.ram_addr] = bus.ram_dout;
      bus.ram_din <= rd;
   end

   function automatic logic [7:0] refRead(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : 8'h00;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      ramMem[a] = b;
      refMem[a] = b;
   endtask

   task automatic checkResetState(input string pfx);
      checkOutput({pfx, "_ram_addr"}, bus.ram_addr, 32'd0);
      checkOutput({pfx, "_ram_wr"}, {31'd0, bus.ram_wr}, 32'd0);
      checkOutput({pfx, "_ram_dout"}, {24'd0, bus.ram_dout}, 32'd0);
      checkOutput({pfx, "_if_data"}, bus.if_data, 32'd0);
      checkOutput({pfx, "_if_done"}, {31'd0, bus.if_done}, 32'd0);
      checkOutput({pfx, "_mem_rdata"}, bus.mem_rdata, 32'd0);
      checkOutput({pfx, "_mem_done"}, {31'd0, bus.mem_done}, 32'd0);
   endtask

   // One access from a single requester, checked cycle by cycle from its cycle 0
   task automatic applyStimulus(input bit isMem, input bit we, input logic [1:0] width,
                                input logic [31:0] addr, input logic [31:0] wdata);
      int n, lat;
      logic [31:0] expData, dataObs;
      bit seen, doneSig, otherDone;
      n   = !isMem ? 4 : (width == 2'b00 ? 1 : (width == 2'b01 ? 2 : 4));
      lat = we ? n + 1 : n + 2;
      expData = 32'd0;
      if (!we) for (int i = 0; i < n; i++) expData[8*i +: 8] = refRead(32'(addr + i));
      seen = 1'b0;
      @(posedge clk); #1;
      if (isMem) begin
         bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_width = width;
         bus.mem_addr = addr; bus.mem_wdata = wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end
      for (int cyc = 0; cyc <= lat + 2; cyc++) begin
         @(negedge clk);
         if (cyc >= 1 && cyc <= n) begin
            checkOutput("ram_addr", bus.ram_addr, 32'(addr + cyc - 1));
            checkOutput("ram_wr", {31'd0, bus.ram_wr}, {31'd0, we});
            if (we) checkOutput("ram_dout", {24'd0, bus.ram_dout}, {24'd0, wdata[8*(cyc-1) +: 8]});
         end else begin
            checkOutput("ram_wr_off", {31'd0, bus.ram_wr}, 32'd0);
         end
         doneSig   = isMem ? bus.mem_done : bus.if_done;
         otherDone = isMem ? bus.if_done : bus.mem_done;
         dataObs   = isMem ? bus.mem_rdata : bus.if_data;
         checkOutput("other_done", {31'd0, otherDone}, 32'd0);
         checkOutput("stall_req", {31'd0, bus.stall_req}, {31'd0, ~doneSig});
         if (doneSig) begin
            seen = 1'b1;
            checkOutput("done_cycle", cyc, lat);
            if (!we) checkOutput("rdata", dataObs, expData);
            break;
         end
      end
      checkOutput("done_seen", {31'd0, seen}, 32'd1);
      @(posedge clk); #1;
      bus.mem_req = 1'b0;
      bus.if_req  = 1'b0;
      if (we) for (int i = 0; i < n; i++) refMem[32'(addr + i)] = wdata[8*i +: 8];
      lastGrantMem = isMem;
   endtask

   // Both requesters present word reads in the same cycle
   task automatic applyTie(input logic [31:0] memAddr, input logic [31:0] ifAddr);
      logic [31:0] expMem, expIf;
      bit winnerMem;
      int memCyc, ifCyc;
      for (int i = 0; i < 4; i++) begin
         expMem[8*i +: 8] = refRead(32'(memAddr + i));
         expIf[8*i +: 8]  = refRead(32'(ifAddr + i));
      end
`ifdef ARB_ROUND_ROBIN_EN
      winnerMem = ~lastGrantMem;
`else
      winnerMem = 1'b1;
`endif
      memCyc = -1;
      ifCyc  = -1;
      @(posedge clk); #1;
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_width = 2'b10; bus.mem_addr = memAddr;
      bus.if_req = 1'b1; bus.if_addr = ifAddr;
      for (int cyc = 0; cyc < 20; cyc++) begin
         bit dropMem, dropIf;
         @(negedge clk);
         dropMem = 1'b0;
         dropIf  = 1'b0;
         if (bus.mem_done) begin
            memCyc = cyc; dropMem = 1'b1;
            checkOutput("tie_mem_rdata", bus.mem_rdata, expMem);
         end
         if (bus.if_done) begin
            ifCyc = cyc; dropIf = 1'b1;
            checkOutput("tie_if_data", bus.if_data, expIf);
         end
         @(posedge clk); #1;
         if (dropMem) bus.mem_req = 1'b0;
         if (dropIf)  bus.if_req  = 1'b0;
         if (memCyc >= 0 && ifCyc >= 0) break;
      end
      bus.mem_req = 1'b0;
      bus.if_req  = 1'b0;
      checkOutput("tie_mem_cycle", memCyc, winnerMem ? 6 : 13);
      checkOutput("tie_if_cycle", ifCyc, winnerMem ? 13 : 6);
      lastGrantMem = ~winnerMem;
   endtask

   initial begin
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = 32'd0;
      bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_width = 2'b00;
      bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1 bus.if_req = 1'b1;
      @(negedge clk);
      checkResetState("por");
      checkOutput("por_stall", {31'd0, bus.stall_req}, 32'd0);
      @(posedge clk); #1;
      bus.if_req = 1'b0;
      rst = 1'b0;
      lastGrantMem = 1'b0;

      for (int i = 0; i < 4; i++) begin
         preload(32'h500 + i, 8'($urandom));
         preload(32'h600 + i, 8'($urandom));
      end
      applyTie(32'h500, 32'h600);
      applyTie(32'h600, 32'h500);

      preload(32'h100, 8'h13); preload(32'h101, 8'h05);
      preload(32'h102, 8'hA0); preload(32'h103, 8'h00);
      applyStimulus(1'b0, 1'b0, 2'b10, 32'h100, 32'd0);

      preload(32'h2002, 8'h11);
      applyStimulus(1'b1, 1'b1, 2'b00, 32'h2003, 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b0, 2'b01, 32'h2002, 32'd0);

      preload(32'hFFFFFFFE, 8'hA1); preload(32'hFFFFFFFF, 8'hB2);
      preload(32'h00000000, 8'hC3); preload(32'h00000001, 8'hD4);
      applyStimulus(1'b1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'd0);

      // Reset landing in cycle 2 of a word write
      @(posedge clk); #1;
      bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_width = 2'b10;
      bus.mem_addr = 32'h4000; bus.mem_wdata = 32'h11223344;
      @(negedge clk);
      checkOutput("rstw_c0_wr", {31'd0, bus.ram_wr}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rstw_c1_wr", {31'd0, bus.ram_wr}, 32'd1);
      checkOutput("rstw_c1_addr", bus.ram_addr, 32'h4000);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rstw_c2_wr", {31'd0, bus.ram_wr}, 32'd0);
      checkOutput("rstw_c2_stall", {31'd0, bus.stall_req}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      @(negedge clk);
      checkResetState("rstw");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("rstw_no_done", {31'd0, bus.mem_done}, 32'd0);
         checkOutput("rstw_no_wr", {31'd0, bus.ram_wr}, 32'd0);
      end
      refMem[32'h4000] = 8'h44;
      lastGrantMem = 1'b0;
      applyStimulus(1'b1, 1'b0, 2'b10, 32'h4000, 32'd0);
      applyStimulus(1'b1, 1'b1, 2'b10, 32'h4000, 32'h11223344);
      applyStimulus(1'b1, 1'b0, 2'b11, 32'h4000, 32'd0);

      for (int it = 0; it < 60; it++) begin
         int kind;
         logic [31:0] a;
         kind = $urandom_range(0, 9);
         a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                         : 32'h3000 + $urandom_range(0, 63);
         if (kind <= 1)
            applyTie(a, 32'h3000 + $urandom_range(0, 63));
         else if (kind <= 3)
            applyStimulus(1'b0, 1'b0, 2'b10, a, 32'd0);
         else
            applyStimulus(1'b1, 1'($urandom), 2'($urandom), a, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
